matrix_row_scanner: RTL and testbench
=====================================

// Module: matrix_row_scanner
// PURPOSE
//  - Downstream consumer of the per-row pattern source: drives the 16x16 LED matrix by
//    time-multiplexing rows.
//  - Generates the 4-bit row index `count` that addresses the pattern source and
//    receives the 16-bit row pattern back on `row_data`.
//  - Registers the pattern and drives it onto the columns while one row is enabled.
//  - Inserts a blanking gap between rows to suppress ghosting.
// PARAMETERS
//  DWELL_CYCLES  1000  clocks a row stays lit (SHOW); legal range >=1
//  BLANK_CYCLES  8     clocks all rows are dark before each row (BLANK); legal range >=1
//  CNT_W         16    width of the internal dwell/blank counter; must hold max(DWELL,BLANK)
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  enable       in   1   1 = scan runs, 0 = display dark and scan parked
//  row_data     in   16  pattern for row `count` (combinational from the pattern source)
//  count        out  4   current row index, sent to the pattern source
//  row_sel      out  16  one-hot row enable, active high; bit n = row n
//  col_out      out  16  column drive, active high; registered copy of row_data
//  frame_start  out  1   one-clock pulse when row 0 is loaded
// BEHAVIOUR
//  - Reset (async assert, sync release) forces:
//    - state=IDLE, count=0, row_sel=0, col_out=0, frame_start=0, timer=0.
//  - All outputs are registered; no combinational path from inputs to outputs.
//  - States: IDLE -> BLANK -> LOAD -> SHOW -> BLANK ...
//  - IDLE:
//    - row_sel=0, col_out=0, count=0.
//    - enable=1 -> BLANK next clock, timer cleared.
//  - BLANK:
//    - row_sel=0, col_out=0, count holds the row about to be shown.
//    - Timer counts BLANK_CYCLES clocks, then LOAD.
//    - BLANK_CYCLES>=1 guarantees row_data has settled for the new count before LOAD.
//  - LOAD (exactly 1 clock):
//    - col_out<=row_data; row_sel<=(16'h1<<count).
//    - frame_start<=1 iff count==0, else 0.
//    - Next state SHOW.
//  - SHOW:
//    - row_sel and col_out held; frame_start=0.
//    - Timer counts DWELL_CYCLES clocks.
//    - On the last SHOW clock: count<=count+1, 4-bit wrap 15->0; next state BLANK.
//    - The outputs clear to 0 on entry to BLANK.
//  - Row period = BLANK_CYCLES+1+DWELL_CYCLES clocks; frame period = 16 x row period.
//  - row_data changes during SHOW are ignored until the next LOAD: no tearing within a row.
//  - enable=0 in any state:
//    - IDLE on the next clock; row_sel=0, col_out=0, count=0, timer=0, frame_start=0.
//    - Re-enable always restarts at row 0 with a full BLANK.
//  - enable falling on the same clock as the LOAD->SHOW or SHOW->BLANK transition:
//    - enable wins; IDLE next.
//  - row_sel is never multi-hot.
//  - row_sel is nonzero only in SHOW and in the clock after LOAD.
//  - Reset mid-row: outputs go dark immediately (asynchronous); scan restarts from row 0.
// TESTING (DWELL_CYCLES=4, BLANK_CYCLES=2, row period 7)
//  1. Reset, enable=1, row_data=16'h1000 for count 0, else 0:
//     - After 2 BLANK + LOAD: row_sel=16'h0001, col_out=16'h1000, frame_start pulses 1 clock.
//     - Held 4 clocks, then both 0.
//  2. Free run 16 rows:
//     - count steps 0..15 every 7 clocks, then wraps to 0.
//     - frame_start spacing = 112 clocks.
//     - row_sel one-hot every SHOW; all-zero in BLANK.
//  3. Toggle row_data mid-SHOW of row 5 from 16'hAAAA to 16'h5555:
//     - col_out stays 16'hAAAA until row 5 ends.
//     - Row 6 loads its own value.
//  4. Drop enable during SHOW of row 9:
//     - Next clock: row_sel=0, col_out=0, count=0.
//     - Re-enable: first LOAD after 2 BLANK clocks is row 0 with frame_start.
//  5. Assert rst_n=0 asynchronously mid-SHOW (between clock edges):
//     - Outputs 0 without waiting for clk.
//     - After release: behaves as test 1.
//  6. Assertion check over a long random enable/row_data run:
//     - $onehot0(row_sel) always holds.
//     - col_out==0 whenever row_sel==0.

Source files
------------

// File: rtl/matrix_row_scanner.sv
// ---------------------------------------------------------------------------
// matrix_row_scanner
//   Time-multiplexed row driver for a 16x16 LED matrix. Walks a 4-bit row
//   index that addresses an external pattern source, latches the returned
//   row pattern onto the columns while exactly one row is enabled, and
//   inserts a dark blanking gap before every row to suppress ghosting.
//
//   Row timeline: BLANK (BLANK_CYCLES) -> LOAD (1) -> SHOW (DWELL_CYCLES).
//   Outputs are visible for the DWELL_CYCLES clocks after LOAD.
//
// Parameters
//   DWELL_CYCLES  clocks a row stays lit (>=1)
//   BLANK_CYCLES  dark clocks before each row (>=1)
//   CNT_W         dwell/blank timer width, must hold max(DWELL, BLANK)
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_enable       1 = scan runs, 0 = display dark and scan parked at row 0
//   i_row_data     pattern for row o_count (combinational from the source)
//   o_count        current row index sent to the pattern source
//   o_row_sel      one-hot row enable, active high
//   o_col_out      column drive, active high, registered copy of i_row_data
//   o_frame_start  one-clock pulse when row 0 is loaded
// ---------------------------------------------------------------------------
module matrix_row_scanner #(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [15:0] i_row_data,
  output logic [3:0]  o_count,
  output logic [15:0] o_row_sel,
  output logic [15:0] o_col_out,
  output logic        o_frame_start
);

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StLoad,
    StShow
  } state_e;

  localparam logic [CNT_W-1:0] BlankLast = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL_CYCLES - 1);

  state_e            r_state;
  logic [CNT_W-1:0]  r_timer;
  logic [3:0]        r_count;
  logic [15:0]       r_row_sel;
  logic [15:0]       r_col_out;
  logic              r_frame_start;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_timer       <= '0;
      r_count       <= 4'd0;
      r_row_sel     <= 16'h0000;
      r_col_out     <= 16'h0000;
      r_frame_start <= 1'b0;
    end else if (!i_enable) begin
      // Disable has priority over every transition and parks the scan at row 0.
      r_state       <= StIdle;
      r_timer       <= '0;
      r_count       <= 4'd0;
      r_row_sel     <= 16'h0000;
      r_col_out     <= 16'h0000;
      r_frame_start <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_state <= StBlank;
          r_timer <= '0;
        end

        StBlank: begin
          if (r_timer == BlankLast) begin
            r_timer <= '0;
            r_state <= StLoad;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        StLoad: begin
          // Pattern has settled for r_count during the blanking gap.
          r_col_out     <= i_row_data;
          r_row_sel     <= 16'h0001 << r_count;
          r_frame_start <= (r_count == 4'd0);
          r_timer       <= '0;
          r_state       <= StShow;
        end

        StShow: begin
          r_frame_start <= 1'b0;
          if (r_timer == DwellLast) begin
            r_timer   <= '0;
            r_count   <= r_count + 4'd1;
            r_row_sel <= 16'h0000;
            r_col_out <= 16'h0000;
            r_state   <= StBlank;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_count       = r_count;
  assign o_row_sel     = r_row_sel;
  assign o_col_out     = r_col_out;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_matrix_row_scanner.sv
// ---------------------------------------------------------------------------
// tb_matrix_row_scanner
//   Bench for matrix_row_scanner with DWELL_CYCLES=4, BLANK_CYCLES=2.
//   Reference model: a single run-length counter m_n (clock edges since the
//   scan left IDLE). Row index and phase follow from plain division by the
//   row period; the column value is the pattern seen at the LOAD edge.
// ---------------------------------------------------------------------------
module tb_matrix_row_scanner;

  localparam int Dwell  = 4;
  localparam int Blank  = 2;
  localparam int Period = Blank + 1 + Dwell;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] row_data;
  logic [15:0] rd_drv;
  logic        use_pat;
  logic [15:0] pat [16];
  logic [3:0]  count;
  logic [15:0] row_sel;
  logic [15:0] col_out;
  logic        frame_start;

  // Pattern source: either a per-row table addressed by count, or a free value.
  assign row_data = use_pat ? pat[count] : rd_drv;

  matrix_row_scanner #(
    .DWELL_CYCLES(Dwell),
    .BLANK_CYCLES(Blank),
    .CNT_W       (16)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_row_data   (row_data),
    .o_count      (count),
    .o_row_sel    (row_sel),
    .o_col_out    (col_out),
    .o_frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_pass;
  int          n_total;
  int          cyc;
  int          m_n;
  logic [15:0] m_col;
  int          fs_times[$];

  typedef struct packed {
    logic        en;
    logic [15:0] rd;
    logic [3:0]  cnt;
    logic [15:0] rs;
    logic [15:0] col;
    logic        fs;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic logic [15:0] pat_val(input int i);
    if (i == 5) return 16'hAAAA;
    return {4'(i), 4'hC, 4'(15 - i), 4'h3};
  endfunction

  // One clock: sample inputs mid-cycle, advance model at the edge, compare after.
  task automatic step();
    logic        s_en;
    logic        s_rst;
    logic [15:0] s_rd;
    int          pos;
    int          row;
    logic [3:0]  e_cnt;
    logic [15:0] e_rs;
    logic        e_fs;
    @(negedge clk);
    s_en  = enable;
    s_rst = rst_n;
    s_rd  = row_data;
    @(posedge clk);
    cyc++;
    if (!s_rst || !s_en) begin
      m_n   = 0;
      m_col = 16'h0;
    end else begin
      m_n++;
      pos = (m_n - 1) % Period;
      if (pos == Blank + 1) m_col = s_rd;
      else if (pos <= Blank) m_col = 16'h0;
    end
    #1;
    if (m_n == 0) begin
      e_cnt = 4'd0;
      e_rs  = 16'h0;
      e_fs  = 1'b0;
    end else begin
      pos   = (m_n - 1) % Period;
      row   = ((m_n - 1) / Period) % 16;
      e_cnt = 4'(row);
      e_rs  = (pos > Blank) ? (16'h0001 << row) : 16'h0;
      e_fs  = (pos == Blank + 1) && (row == 0);
    end
    chk("model_count", 32'(count), 32'(e_cnt));
    chk("model_row_sel", 32'(row_sel), 32'(e_rs));
    chk("model_col_out", 32'(col_out), 32'(m_col));
    chk("model_frame_start", 32'(frame_start), 32'(e_fs));
    chk("onehot0_row_sel", 32'($onehot0(row_sel)), 32'd1);
    chk("dark_cols_when_unselected", 32'((row_sel != 16'h0) || (col_out == 16'h0)), 32'd1);
    if (frame_start) fs_times.push_back(cyc);
  endtask

  task automatic wait_show(input logic [3:0] row);
    int k;
    k = 0;
    while (!(count == row && row_sel != 16'h0) && k < 300) begin
      step();
      k++;
    end
    chk("wait_row_show", 32'(count == row && row_sel != 16'h0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    cyc     = 0;
    m_n     = 0;
    m_col   = 16'h0;
    rst_n   = 1'b0;
    enable  = 1'b0;
    use_pat = 1'b0;
    rd_drv  = 16'h0;
    for (int i = 0; i < 16; i++) pat[i] = pat_val(i);

    //             en    rd        cnt   row_sel   col_out   fs
    vecs[0]  = '{1'b1, 16'h1000, 4'd0, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 16'h1000, 4'd0, 16'h0000, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 16'h1000, 4'd0, 16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 16'h1000, 4'd0, 16'h0001, 16'h1000, 1'b1};
    vecs[4]  = '{1'b1, 16'h1000, 4'd0, 16'h0001, 16'h1000, 1'b0};
    vecs[5]  = '{1'b1, 16'h1000, 4'd0, 16'h0001, 16'h1000, 1'b0};
    vecs[6]  = '{1'b1, 16'h1000, 4'd0, 16'h0001, 16'h1000, 1'b0};
    vecs[7]  = '{1'b1, 16'h1000, 4'd1, 16'h0000, 16'h0000, 1'b0};
    vecs[8]  = '{1'b1, 16'h0000, 4'd1, 16'h0000, 16'h0000, 1'b0};
    vecs[9]  = '{1'b1, 16'h0000, 4'd1, 16'h0000, 16'h0000, 1'b0};
    vecs[10] = '{1'b1, 16'h0000, 4'd1, 16'h0002, 16'h0000, 1'b0};
    vecs[11] = '{1'b0, 16'h0000, 4'd0, 16'h0000, 16'h0000, 1'b0};
    vecs[12] = '{1'b0, 16'h1000, 4'd0, 16'h0000, 16'h0000, 1'b0};
    vecs[13] = '{1'b1, 16'h1000, 4'd0, 16'h0000, 16'h0000, 1'b0};

    // Reset state
    step();
    step();
    rst_n = 1'b1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_row_sel", 32'(row_sel), 32'd0);
    chk("reset_col_out", 32'(col_out), 32'd0);
    chk("reset_frame_start", 32'(frame_start), 32'd0);
    step();

    // First row after enable, hold, blank, row 1, disable and re-enable
    for (int i = 0; i < 14; i++) begin
      enable = vecs[i].en;
      rd_drv = vecs[i].rd;
      step();
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_row_sel", i), 32'(row_sel), 32'(vecs[i].rs));
      chk($sformatf("vec%0d_col_out", i), 32'(col_out), 32'(vecs[i].col));
      chk($sformatf("vec%0d_frame_start", i), 32'(frame_start), 32'(vecs[i].fs));
    end

    // Free run over two frames
    use_pat = 1'b1;
    fs_times.delete();
    for (int i = 0; i < 240; i++) step();
    chk("frame_pulse_count", 32'(fs_times.size() >= 2), 32'd1);
    for (int i = 1; i < fs_times.size(); i++)
      chk("frame_spacing", 32'(fs_times[i] - fs_times[i-1]), 32'(16 * Period));

    // Pattern change mid-row must not tear
    wait_show(4'd5);
    chk("row5_loaded", 32'(col_out), 32'(16'hAAAA));
    pat[5] = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("row5_no_tear", 32'(col_out), 32'(16'hAAAA));
    end
    wait_show(4'd6);
    chk("row6_own_value", 32'(col_out), 32'(pat_val(6)));
    pat[5] = 16'hAAAA;

    // Drop enable during row 9, then restart from row 0
    wait_show(4'd9);
    enable = 1'b0;
    step();
    chk("disable_row_sel", 32'(row_sel), 32'd0);
    chk("disable_col_out", 32'(col_out), 32'd0);
    chk("disable_count", 32'(count), 32'd0);
    step();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reenable_dark", 32'(row_sel), 32'd0);
    end
    step();
    chk("reenable_row0_sel", 32'(row_sel), 32'h0001);
    chk("reenable_frame_start", 32'(frame_start), 32'd1);
    chk("reenable_col", 32'(col_out), 32'(pat_val(0)));

    // Asynchronous reset between clock edges
    wait_show(4'd3);
    #2;
    rst_n = 1'b0;
    m_n   = 0;
    m_col = 16'h0;
    #1;
    chk("async_rst_row_sel", 32'(row_sel), 32'd0);
    chk("async_rst_col_out", 32'(col_out), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_frame_start", 32'(frame_start), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    step();
    chk("post_rst_row0_sel", 32'(row_sel), 32'h0001);
    chk("post_rst_frame_start", 32'(frame_start), 32'd1);

    // Random enable and pattern stress against the model
    use_pat = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      enable = ($urandom_range(0, 149) != 0);
      rd_drv = 16'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
